// File: rtl/crc_pkg.sv
// Shared CRC-32 constants, FSM state type and the single-byte step function.
package crc_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } crc_state_e;

    // Eight MSB-first serial-division steps. Folding the byte into the top of
    // the register first is equivalent to feeding its bits one at a time.
    function automatic logic [31:0] crc_byte_step(input logic [31:0] crc,
                                                  input logic [7:0]  data_byte,
                                                  input logic [31:0] poly);
        logic [31:0] c;
        c = crc ^ {data_byte, 24'h000000};
        for (int i = 0; i < 8; i++) begin
            c = c[31] ? ({c[30:0], 1'b0} ^ poly) : {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_lane_chain.sv
// Combinational chain of byte steps; crc_out[k] is the CRC after bytes 0..k.
module crc_lane_chain
    import crc_pkg::*;
#(
    parameter int          DATA_BYTES = 8,
    parameter logic [31:0] POLY       = CRC32_POLY
) (
    input  logic [31:0]                  crc_in,
    input  logic [8*DATA_BYTES-1:0]      data,
    output logic [DATA_BYTES-1:0][31:0]  crc_out
);

    // Byte 0 sits in the top lane; every tap exposes the partial result.
    always_comb begin
        logic [31:0] c;
        c       = crc_in;
        crc_out = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            c          = crc_byte_step(c, data[8*(DATA_BYTES-i)-1 -: 8], POLY);
            crc_out[i] = c;
        end
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC-32 generator/checker with sop/eop framing, abort and a
// registered result (value + residue check) one cycle after eop.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int          DATA_BYTES = 8,
    parameter logic [31:0] POLY       = CRC32_POLY,
    parameter logic [31:0] INIT       = CRC32_INIT,
    parameter logic [31:0] RESIDUE    = CRC32_RESIDUE,
    parameter int          CNT_W      = $clog2(DATA_BYTES) + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    d_valid,
    input  logic                    sop,
    input  logic                    eop,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic [CNT_W-1:0]        bytes_valid,
    input  logic                    abort,
    output logic [31:0]             crc_value,
    output logic                    crc_done,
    output logic                    crc_ok,
    output logic                    busy,
    output logic                    err_sop
);

    crc_state_e                  state, state_nxt;
    logic [31:0]                 crc_reg, crc_nxt;
    logic [31:0]                 chain_base;
    logic [31:0]                 step_full;
    logic [31:0]                 step_eop;
    logic [DATA_BYTES-1:0][31:0] chain;
    logic                        done_nxt;
    logic                        err_nxt;
    int                          n_used;

    // A sop always restarts from INIT, even when it lands inside a frame.
    assign chain_base = ((state == ST_FRAME) && !sop) ? crc_reg : INIT;

    crc_lane_chain #(
        .DATA_BYTES (DATA_BYTES),
        .POLY       (POLY)
    ) u_chain (
        .crc_in  (chain_base),
        .data    (data),
        .crc_out (chain)
    );

    assign step_full = chain[DATA_BYTES-1];
    assign busy      = (state == ST_FRAME);

    // Pick the tap for the eop byte count; out-of-range counts mean a full word.
    always_comb begin
        n_used = DATA_BYTES;
        if (eop && (bytes_valid != '0) && (int'(bytes_valid) <= DATA_BYTES))
            n_used = int'(bytes_valid);
        step_eop = chain[DATA_BYTES-1];
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (n_used == i + 1)
                step_eop = chain[i];
        end
    end

    // Next-state, next-CRC and result strobes; abort overrides everything.
    always_comb begin
        state_nxt = state;
        crc_nxt   = crc_reg;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (abort) begin
            state_nxt = ST_IDLE;
            crc_nxt   = INIT;
        end else if (d_valid) begin
            if (sop) begin
                err_nxt = (state == ST_FRAME);
                if (eop) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                    crc_nxt   = INIT;
                end else begin
                    state_nxt = ST_FRAME;
                    crc_nxt   = step_full;
                end
            end else if (state == ST_FRAME) begin
                if (eop) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                    crc_nxt   = INIT;
                end else begin
                    crc_nxt   = step_full;
                end
            end
        end
    end

    // State and running CRC register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            crc_reg <= INIT;
        end else begin
            state   <= state_nxt;
            crc_reg <= crc_nxt;
        end
    end

    // Result registers: value/ok hold between completions, strobes pulse once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_value <= '0;
            crc_ok    <= 1'b0;
            crc_done  <= 1'b0;
            err_sop   <= 1'b0;
        end else begin
            crc_done <= done_nxt;
            err_sop  <= err_nxt;
            if (done_nxt) begin
                crc_value <= step_eop;
                crc_ok    <= (step_eop == RESIDUE);
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Randomized self-checking bench for crc_stream_engine with a byte-queue
// reference model; golden vectors also run on 4- and 16-byte instances.
module tb_crc_stream_engine;

    localparam int          DB  = 8;
    localparam int          CW  = $clog2(DB) + 1;
    localparam logic [31:0] P   = 32'h04C11DB7;
    localparam logic [31:0] I   = 32'hFFFFFFFF;
    localparam logic [31:0] R   = 32'hC704DD7B;
    localparam logic [63:0] W0  = 64'h3132333435363738;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // main DUT (8 bytes)
    logic            d_valid, sop, eop, abort;
    logic [8*DB-1:0] data;
    logic [CW-1:0]   bytes_valid;
    logic [31:0]     crc_value;
    logic            crc_done, crc_ok, busy, err_sop;

    // 4-byte instance
    logic        d4_valid, d4_sop, d4_eop, d4_abort;
    logic [31:0] d4_data;
    logic [2:0]  d4_bv;
    logic [31:0] d4_value;
    logic        d4_done, d4_ok, d4_busy, d4_err;

    // 16-byte instance
    logic         d16_valid, d16_sop, d16_eop, d16_abort;
    logic [127:0] d16_data;
    logic [4:0]   d16_bv;
    logic [31:0]  d16_value;
    logic         d16_done, d16_ok, d16_busy, d16_err;

    crc_stream_engine #(.DATA_BYTES(DB)) dut (
        .clk(clk), .reset_n(reset_n), .d_valid(d_valid), .sop(sop), .eop(eop),
        .data(data), .bytes_valid(bytes_valid), .abort(abort),
        .crc_value(crc_value), .crc_done(crc_done), .crc_ok(crc_ok),
        .busy(busy), .err_sop(err_sop)
    );

    crc_stream_engine #(.DATA_BYTES(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .d_valid(d4_valid), .sop(d4_sop), .eop(d4_eop),
        .data(d4_data), .bytes_valid(d4_bv), .abort(d4_abort),
        .crc_value(d4_value), .crc_done(d4_done), .crc_ok(d4_ok),
        .busy(d4_busy), .err_sop(d4_err)
    );

    crc_stream_engine #(.DATA_BYTES(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .d_valid(d16_valid), .sop(d16_sop), .eop(d16_eop),
        .data(d16_data), .bytes_valid(d16_bv), .abort(d16_abort),
        .crc_value(d16_value), .crc_done(d16_done), .crc_ok(d16_ok),
        .busy(d16_busy), .err_sop(d16_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: bit-serial CRC over a byte list, MSB-first, no final xor.
    function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
        logic [31:0] c;
        logic        fb;
        c = I;
        foreach (q[k]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[31] ^ q[k][b];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ P;
            end
        end
        return c;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // model state for the main DUT
    logic [7:0]  frame_q[$];
    logic [7:0]  gq[$];
    bit          m_in_frame = 1'b0;
    logic [31:0] m_val = 32'h0;
    bit          m_ok = 1'b0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;

    task automatic model_finish();
        m_val      = ref_crc(frame_q);
        m_ok       = (m_val == R);
        m_done     = 1'b1;
        m_in_frame = 1'b0;
        frame_q.delete();
    endtask

    // One beat on the main DUT, model update, then compare all outputs.
    task automatic drive8(input bit v, input bit s, input bit e, input bit a,
                          input logic [8*DB-1:0] w, input logic [CW-1:0] bv);
        int n;
        @(negedge clk);
        d_valid = v; sop = s; eop = e; abort = a; data = w; bytes_valid = bv;
        m_done = 1'b0;
        m_err  = 1'b0;
        n = DB;
        if (e && int'(bv) != 0 && int'(bv) <= DB) n = int'(bv);
        if (a) begin
            m_in_frame = 1'b0;
            frame_q.delete();
        end else if (v) begin
            if (s) begin
                m_err = m_in_frame;
                frame_q.delete();
                for (int i = 0; i < n; i++) frame_q.push_back(w[8*(DB-1-i) +: 8]);
                if (e) model_finish();
                else   m_in_frame = 1'b1;
            end else if (m_in_frame) begin
                for (int i = 0; i < n; i++) frame_q.push_back(w[8*(DB-1-i) +: 8]);
                if (e) model_finish();
            end
        end
        @(posedge clk);
        #1;
        chk("crc_done",  32'(crc_done), 32'(m_done));
        chk("err_sop",   32'(err_sop),  32'(m_err));
        chk("busy",      32'(busy),     32'(m_in_frame));
        chk("crc_value", crc_value,     m_val);
        chk("crc_ok",    32'(crc_ok),   32'(m_ok));
    endtask

    task automatic idle8();
        drive8(1'b0, 1'b0, 1'b0, 1'b0, rnd64(), CW'($urandom));
    endtask

    // Golden "123456789" frame, optionally with its complemented CRC appended.
    task automatic gold8(input bit fcs, input int gap);
        drive8(1'b1, 1'b1, 1'b0, 1'b0, W0, CW'($urandom));
        for (int g = 0; g < gap; g++) begin
            idle8();
            chk("gap_busy", 32'(busy), 32'd1);
        end
        if (fcs) drive8(1'b1, 1'b0, 1'b1, 1'b0, {8'h39, 32'hFC891918, 24'($urandom)}, CW'(5));
        else     drive8(1'b1, 1'b0, 1'b1, 1'b0, {8'h39, 56'($urandom)}, CW'(1));
        chk("gold_value", crc_value, fcs ? R : 32'h0376E6E7);
        chk("gold_ok",    32'(crc_ok), 32'(fcs));
    endtask

    task automatic send4();
        int          nw, idx;
        logic [31:0] exp;
        exp = ref_crc(gq);
        nw  = (gq.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                idx = 4*w + j;
                d4_data[8*(3-j) +: 8] = (idx < gq.size()) ? gq[idx] : 8'($urandom);
            end
            d4_valid = 1'b1;
            d4_sop   = (w == 0);
            d4_eop   = (w == nw - 1);
            d4_bv    = 3'(gq.size() - 4*w);
            @(posedge clk);
            #1;
        end
        chk("d4_done",  32'(d4_done), 32'd1);
        chk("d4_value", d4_value, exp);
        chk("d4_ok",    32'(d4_ok), 32'(exp == R));
        @(negedge clk);
        d4_valid = 1'b0; d4_sop = 1'b0; d4_eop = 1'b0;
        @(posedge clk);
        #1;
        chk("d4_done_pulse", 32'(d4_done), 32'd0);
    endtask

    task automatic send16();
        logic [31:0] exp;
        exp = ref_crc(gq);
        @(negedge clk);
        for (int j = 0; j < 16; j++)
            d16_data[8*(15-j) +: 8] = (j < gq.size()) ? gq[j] : 8'($urandom);
        d16_valid = 1'b1; d16_sop = 1'b1; d16_eop = 1'b1;
        d16_bv    = 5'(gq.size());
        @(posedge clk);
        #1;
        chk("d16_done",  32'(d16_done), 32'd1);
        chk("d16_value", d16_value, exp);
        chk("d16_ok",    32'(d16_ok), 32'(exp == R));
        @(negedge clk);
        d16_valid = 1'b0; d16_sop = 1'b0; d16_eop = 1'b0;
    endtask

    initial begin
        logic [7:0]      rq[$];
        logic [8*DB-1:0] w;
        logic [CW-1:0]   bv;
        int              len, nw, rem;
        bit              s, a;

        d_valid = 0; sop = 0; eop = 0; abort = 0; data = '0; bytes_valid = '0;
        d4_valid = 0; d4_sop = 0; d4_eop = 0; d4_abort = 0; d4_data = '0; d4_bv = '0;
        d16_valid = 0; d16_sop = 0; d16_eop = 0; d16_abort = 0; d16_data = '0; d16_bv = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_value", crc_value, 32'h0);
        chk("rst_done",  32'(crc_done), 32'd0);
        chk("rst_ok",    32'(crc_ok), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_err",   32'(err_sop), 32'd0);
        reset_n = 1'b1;

        // golden frames, back-to-back, with gaps
        gold8(1'b0, 0);
        gold8(1'b1, 0);
        gold8(1'b1, 3);

        // stray non-sop word while idle is ignored
        drive8(1'b1, 1'b0, 1'b1, 1'b0, rnd64(), CW'(3));

        // sop mid-frame: first frame dropped, second one completes
        drive8(1'b1, 1'b1, 1'b0, 1'b0, W0, CW'(0));
        gold8(1'b1, 0);

        // abort coincident with eop discards the frame
        drive8(1'b1, 1'b1, 1'b0, 1'b0, W0, CW'(0));
        drive8(1'b1, 1'b0, 1'b1, 1'b1, {8'h39, 32'hFC891918, 24'h0}, CW'(5));
        chk("abort_no_done", 32'(crc_done), 32'd0);
        gold8(1'b1, 0);

        // abort right after eop does not cancel the result
        drive8(1'b1, 1'b1, 1'b0, 1'b0, W0, CW'(0));
        drive8(1'b1, 1'b0, 1'b1, 1'b0, {8'h39, 56'h0}, CW'(1));
        drive8(1'b0, 1'b0, 1'b0, 1'b1, rnd64(), CW'(0));
        chk("abort_after_hold", crc_value, 32'h0376E6E7);

        // out-of-range byte counts on a full eop word
        drive8(1'b1, 1'b1, 1'b1, 1'b0, W0, CW'(0));
        drive8(1'b1, 1'b1, 1'b1, 1'b0, W0, CW'(13));

        // async reset mid-frame
        drive8(1'b1, 1'b1, 1'b0, 1'b0, W0, CW'(0));
        @(negedge clk);
        d_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_value", crc_value, 32'h0);
        chk("midrst_ok",    32'(crc_ok), 32'd0);
        chk("midrst_busy",  32'(busy), 32'd0);
        chk("midrst_done",  32'(crc_done), 32'd0);
        m_in_frame = 1'b0; m_val = 32'h0; m_ok = 1'b0;
        frame_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        gold8(1'b1, 0);

        // randomized frames: gaps, stray sops, aborts, odd byte counts
        for (int f = 0; f < 200; f++) begin
            len = $urandom_range(1, 40);
            nw  = (len + DB - 1) / DB;
            if ($urandom_range(0, 9) == 0)
                drive8(1'b1, 1'b0, 1'($urandom), 1'b0, rnd64(), CW'($urandom));
            for (int k = 0; k < nw; k++) begin
                if ($urandom_range(0, 3) == 0)
                    repeat ($urandom_range(1, 2)) idle8();
                s   = (k == 0) || ($urandom_range(0, 24) == 0);
                a   = ($urandom_range(0, 29) == 0);
                rem = len - DB*k;
                w   = rnd64();
                bv  = CW'(rem);
                if (rem >= DB) begin
                    bv = CW'(DB);
                    if ($urandom_range(0, 1) == 0)
                        bv = ($urandom_range(0, 1) == 0) ? CW'(0) : CW'($urandom_range(DB + 1, 2**CW - 1));
                end
                drive8(1'b1, s, (k == nw - 1), a, w, bv);
            end
        end

        // golden vectors on the 4- and 16-byte instances
        rq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        gq = rq;
        send4();
        send16();
        chk("d16_gold9", d16_value, 32'h0376E6E7);
        rq.push_back(8'hFC); rq.push_back(8'h89); rq.push_back(8'h19); rq.push_back(8'h18);
        gq = rq;
        send4();
        chk("d4_gold13", d4_value, R);
        send16();
        chk("d16_gold13", d16_value, R);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Parametrised successor to the rx CRC block: a streaming CRC-32 generator/checker for the 10G rx/tx datapath.
- Accepts DATA_BYTES-wide words with sop/eop framing and a last-word byte count.
- Computes the running CRC across the frame and, one cycle after eop, reports the final CRC value plus a residue-based FCS pass/fail flag.
- Sits between the rx datapath alignment stage and the frame status logic; also usable on tx for FCS generation.

Parameters:
- DATA_BYTES, 8, bytes per input word (1,2,4,8,16); byte 0 at data[8*DATA_BYTES-1 -: 8].
- POLY, 32'h04C11DB7, generator polynomial, x^32 implicit, non-reflected.
- INIT, 32'hFFFFFFFF, CRC register value at sop.
- RESIDUE, 32'hC704DD7B, expected final register value when the frame includes its complemented FCS.
- CNT_W, $clog2(DATA_BYTES)+1, width of bytes_valid.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- d_valid  in  1  word valid this cycle.
- sop  in  1  first word of frame; qualified by d_valid.
- eop  in  1  last word of frame; qualified by d_valid.
- data  in  8*DATA_BYTES  word; bytes MSB-first, bits MSB-first within each byte.
- bytes_valid  in  CNT_W  valid bytes in eop word, 1..DATA_BYTES; ignored when eop=0.
- abort  in  1  discard current frame.
- crc_value  out  32  final CRC register (no final xor) of the completed frame.
- crc_done  out  1  one-cycle pulse: crc_value/crc_ok valid.
- crc_ok  out  1  crc_value == RESIDUE.
- busy  out  1  high while in FRAME state.
- err_sop  out  1  one-cycle pulse: sop received while in FRAME (previous frame dropped).

Behaviour:
- Reset (reset_n=0, async):
  - crc_reg=INIT, crc_value=0, crc_done=0, crc_ok=0, busy=0, err_sop=0, state=IDLE.
- Step function:
  - Per byte: 8 MSB-first serial-division steps with POLY.
  - A word with n valid bytes applies n byte steps to bytes 0..n-1; unused bytes are ignored, not zero-fed.
- FSM states: IDLE, FRAME.
  - IDLE, d_valid & sop & ~eop: crc_reg <= step(INIT, all bytes); go to FRAME.
  - IDLE, d_valid & sop & eop (single-word frame): result computed from INIT over bytes_valid bytes; crc_done next cycle; stay in IDLE.
  - IDLE, d_valid & ~sop: word ignored, no outputs.
  - FRAME, d_valid & ~sop & ~eop: crc_reg <= step(crc_reg, all bytes).
  - FRAME, d_valid & eop: final = step(crc_reg, bytes_valid bytes); go to IDLE; crc_reg <= INIT.
  - FRAME, d_valid & sop: err_sop pulses; restart from INIT with this word, same as the IDLE+sop rules. No crc_done for the dropped frame.
  - FRAME, d_valid=0: hold crc_reg; no timeout.
- Latency:
  - crc_value, crc_ok and crc_done are registered and appear exactly 1 cycle after the eop beat.
  - crc_value/crc_ok hold until the next crc_done.
  - crc_done is a single-cycle pulse; back-to-back frames may give crc_done on consecutive cycles.
- abort:
  - Highest priority after reset: state <= IDLE, crc_reg <= INIT, no crc_done.
  - An eop beat in the same cycle as abort is discarded.
  - An abort in the cycle after eop does not cancel the pending crc_done.
- bytes_valid:
  - A value of 0 or >DATA_BYTES on an eop beat is treated as DATA_BYTES.
- Width rules:
  - All CRC arithmetic is 32-bit; the byte-lane mux is built for any DATA_BYTES power of two up to 16.

Decomposition:
- Shared package crc_pkg: CRC32_POLY, CRC32_INIT, CRC32_RESIDUE constants; a crc_byte_step function (32-bit crc, 8-bit byte, poly) returning the next crc.
- Sub-module crc_lane_chain: combinational chain of DATA_BYTES byte steps exposing the crc after each byte count 1..DATA_BYTES. The top level selects from this chain with bytes_valid and contains the FSM and output registers.

Test Plan:
- DATA_BYTES=8, INIT=FFFFFFFF, no abort. Frame "123456789" sent as word 0x3132333435363738 (sop), then 0x39xxxxxxxxxxxxxx with eop and bytes_valid=1 -> 1 cycle later crc_done=1, crc_value=0x0376E6E7, crc_ok=0.
- Same frame plus appended bytes FC 89 19 18 (complemented CRC, so the eop word holds 5 valid bytes) -> crc_value=0xC704DD7B, crc_ok=1.
- Same 13-byte frame with d_valid gaps of 3 idle cycles between words -> identical crc_value/crc_ok; busy high throughout the gap.
- sop mid-frame after one word, then a full valid frame -> err_sop pulses once, a single crc_done occurs, and crc_ok=1 for the second frame only.
- abort asserted coincident with the eop beat -> no crc_done; the next frame gives correct results from INIT.
- reset_n dropped mid-frame, then released and the golden frame resent -> all outputs 0 during reset; crc_ok=1 afterwards. Repeat the golden vectors with DATA_BYTES=4 and 16 for identical results.
